nes_palette_loader: RTL

Converts the byte-serial palette file stream from the HPS download interface into the 24-bit per-entry write strobes consumed by the video output stage (`load_color`, `load_color_data`, `load_color_index`). Sits directly upstream of the video enclosure. Assembles R,G,B byte triples into one colour word and emits one single-cycle write per completed entry. Reports when a full 64-entry palette has been delivered.

---
 rtl/nes_palette_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/nes_palette_loader.sv
`default_nettype none
// ============================================================================
// nes_palette_loader : packs HPS palette bytes (R,G,B) into 24-bit colour writes
// Revision 1.0
// ============================================================================
module nes_palette_loader #(
  parameter logic [7:0] PAL_INDEX  = 8'h02,
  parameter int         NUM_COLORS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        pal_loaded,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [6:0] c_num_colors = 7'(NUM_COLORS);
  localparam logic [6:0] c_last_entry = 7'(NUM_COLORS - 1);

  state_t      state_q;
  logic        dl_q;
  logic [1:0]  byte_sel_q;
  logic [6:0]  entry_cnt_q;
  logic [7:0]  red_q;
  logic [7:0]  green_q;
  logic        load_color_q;
  logic [23:0] load_color_data_q;
  logic [5:0]  load_color_index_q;
  logic        pal_loaded_q;

  logic w_index_match;
  logic w_start;
  logic w_byte;

  assign w_index_match = (ioctl_index == PAL_INDEX);
  assign w_start       = ioctl_download & ~dl_q & w_index_match;
  assign w_byte        = ioctl_wr & w_index_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      // Tracks the level even in reset so a download already in flight
      // cannot look like a fresh rising edge once reset is released.
      dl_q               <= ioctl_download;
      byte_sel_q         <= 2'd0;
      entry_cnt_q        <= 7'd0;
      red_q              <= 8'h00;
      green_q            <= 8'h00;
      load_color_q       <= 1'b0;
      load_color_data_q  <= 24'h0;
      load_color_index_q <= 6'd0;
      pal_loaded_q       <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      load_color_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            state_q      <= ST_COLLECT;
            byte_sel_q   <= 2'd0;
            entry_cnt_q  <= 7'd0;
            pal_loaded_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (!ioctl_download) begin
            state_q    <= ST_IDLE;
            byte_sel_q <= 2'd0;
          end else if (w_byte) begin
            case (byte_sel_q)
              2'd0: begin
                red_q      <= ioctl_dout;
                byte_sel_q <= 2'd1;
              end
              2'd1: begin
                green_q    <= ioctl_dout;
                byte_sel_q <= 2'd2;
              end
              default: begin
                byte_sel_q         <= 2'd0;
                load_color_q       <= 1'b1;
                load_color_data_q  <= {red_q, green_q, ioctl_dout};
                load_color_index_q <= entry_cnt_q[5:0];
                if (entry_cnt_q != c_num_colors) begin
                  entry_cnt_q <= entry_cnt_q + 7'd1;
                end
                if (entry_cnt_q == c_last_entry) begin
                  state_q      <= ST_FULL;
                  pal_loaded_q <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_FULL: begin
          if (!ioctl_download) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_color       = load_color_q;
  assign load_color_data  = load_color_data_q;
  assign load_color_index = load_color_index_q;
  assign pal_loaded       = pal_loaded_q;
  assign busy             = (state_q == ST_COLLECT);

endmodule
`default_nettype wire
